// File: rtl/mic_pkg.sv
`default_nettype none
// mic_pkg -- shared defaults, entry layout and partition helper for mic_rr_queue.
// Revision 1.0
package mic_pkg;

  localparam int MIC_NREQS  = 4;
  localparam int MIC_PSIZE  = 20;
  localparam int MIC_MWIDTH = 32;
  localparam int MIC_RDEPTH = 6;
  localparam int MIC_AWIDTH = $clog2(MIC_NREQS * MIC_PSIZE);
  localparam int MIC_RBITS  = $clog2(MIC_NREQS);

  typedef struct packed {
    logic [MIC_RBITS-1:0]  rid;
    logic                  we;
    logic [MIC_AWIDTH-1:0] addr;
    logic [MIC_MWIDTH-1:0] wdata;
    logic                  err;
  } req_entry_t;

  // Requestor rid owns addresses [rid*psize, rid*psize+psize-1].
  function automatic logic in_partition(input int rid, input int addr, input int psize);
    return (addr >= rid * psize) && (addr < rid * psize + psize);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic_rr_arb.sv
`default_nettype none
// mic_rr_arb -- NREQS-way round-robin arbiter with one-hot combinational grant.
// Revision 1.0
module mic_rr_arb #(
  parameter  int NREQS = 4,
  localparam int RBITS = $clog2(NREQS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQS-1:0] valid,
  output logic [NREQS-1:0] grant,
  output logic [RBITS-1:0] gidx
);

  logic [RBITS-1:0] rr;
  logic [RBITS:0]   sum;
  logic [RBITS-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQS; i++) begin
      sum = {1'b0, rr} + (RBITS+1)'(i);
      if (sum >= (RBITS+1)'(NREQS))
        sum = sum - (RBITS+1)'(NREQS);
      idx = sum[RBITS-1:0];
      if (en && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr <= '0;
    else if (found)
      rr <= (gidx == RBITS'(NREQS - 1)) ? '0 : gidx + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/mic_rr_queue.sv
`default_nettype none
// mic_rr_queue -- round-robin request queue in front of a single-port memory,
// with partition protection and tagged responses. Revision 1.0
module mic_rr_queue
  import mic_pkg::*;
#(
  parameter  int NREQS   = MIC_NREQS,
  parameter  int PSIZE   = MIC_PSIZE,
  parameter  int MWIDTH  = MIC_MWIDTH,
  parameter  int RDEPTH  = MIC_RDEPTH,
  parameter  int PROTECT = 1,
  localparam int AWIDTH  = $clog2(NREQS * PSIZE),
  localparam int RBITS   = $clog2(NREQS),
  localparam int CBITS   = $clog2(RDEPTH + 1),
  localparam int PBITS   = $clog2(RDEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQS-1:0]        req_valid,
  output logic [NREQS-1:0]        req_ready,
  input  logic [NREQS-1:0]        req_we,
  input  logic [NREQS*AWIDTH-1:0] req_addr,
  input  logic [NREQS*MWIDTH-1:0] req_wdata,
  input  logic                    mem_gnt,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [AWIDTH-1:0]       mem_addr,
  output logic [MWIDTH-1:0]       mem_wdata,
  input  logic [MWIDTH-1:0]       mem_rdata,
  output logic                    rsp_valid,
  output logic [RBITS-1:0]        rsp_rid,
  output logic                    rsp_err,
  output logic [MWIDTH-1:0]       rsp_rdata,
  output logic [CBITS-1:0]        q_count,
  output logic [15:0]             err_cnt
);

  typedef struct packed {
    logic [RBITS-1:0]  rid;
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [MWIDTH-1:0] wdata;
    logic              err;
  } entry_t;

  entry_t            q [RDEPTH];
  entry_t            head;
  logic [PBITS-1:0]  wptr, rptr;
  logic [NREQS-1:0]  grant;
  logic [RBITS-1:0]  gidx;
  logic              can_push, push, pop, empty, rd_ok;
  logic [AWIDTH-1:0] in_addr;
  logic [MWIDTH-1:0] in_wdata;
  logic              in_we, in_err;

  // Full blocks grants even if the head pops in the same cycle.
  assign can_push = !rst && (q_count < CBITS'(RDEPTH));

  mic_rr_arb #(.NREQS(NREQS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (can_push),
    .valid (req_valid),
    .grant (grant),
    .gidx  (gidx)
  );

  assign req_ready = grant;
  assign push      = |grant;
  assign in_addr   = req_addr[gidx*AWIDTH +: AWIDTH];
  assign in_wdata  = req_wdata[gidx*MWIDTH +: MWIDTH];
  assign in_we     = req_we[gidx];
  assign in_err    = (PROTECT != 0) && !in_partition(int'(gidx), int'(in_addr), PSIZE);

  assign empty = (q_count == '0);
  assign head  = q[rptr];
  // Faulting entries retire without waiting for the memory.
  assign pop   = !rst && !empty && (head.err || mem_gnt);

  assign mem_en    = !rst && !empty && !head.err && mem_gnt;
  assign mem_we    = head.we;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.wdata;

  always_ff @(posedge clk) begin
    if (push)
      q[wptr] <= '{rid: gidx, we: in_we, addr: in_addr, wdata: in_wdata, err: in_err};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      q_count <= '0;
    end else begin
      if (push)
        wptr <= (wptr == PBITS'(RDEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)
        rptr <= (rptr == PBITS'(RDEPTH - 1)) ? '0 : rptr + 1'b1;
      if (push && !pop)
        q_count <= q_count + 1'b1;
      else if (!push && pop)
        q_count <= q_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rid   <= '0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= pop;
      rd_ok     <= pop && !head.err && !head.we;
      if (pop) begin
        rsp_rid <= head.rid;
        rsp_err <= head.err;
      end
      if (pop && head.err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  // Read data arrives from memory in the response cycle itself.
  assign rsp_rdata = rd_ok ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mic_rr_queue.sv
`default_nettype none
// tb_mic_rr_queue -- directed, table-driven bench for mic_rr_queue.
// Revision 1.0
module tb_mic_rr_queue;

  localparam int NREQS = 4, PSIZE = 20, MWIDTH = 32, RDEPTH = 6;
  localparam int AWIDTH = 7, RBITS = 2, CBITS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQS-1:0]        req_valid, req_ready, req_we;
  logic [NREQS*AWIDTH-1:0] req_addr;
  logic [NREQS*MWIDTH-1:0] req_wdata;
  logic                    mem_gnt, mem_en, mem_we;
  logic [AWIDTH-1:0]       mem_addr;
  logic [MWIDTH-1:0]       mem_wdata, mem_rdata, rsp_rdata;
  logic                    rsp_valid, rsp_err;
  logic [RBITS-1:0]        rsp_rid;
  logic [CBITS-1:0]        q_count;
  logic [15:0]             err_cnt;

  logic [NREQS-1:0]  np_ready;
  logic              np_mem_en, np_mem_we, np_rsp_valid, np_rsp_err;
  logic [AWIDTH-1:0] np_mem_addr;
  logic [MWIDTH-1:0] np_mem_wdata, np_rsp_rdata;
  logic [RBITS-1:0]  np_rsp_rid;
  logic [CBITS-1:0]  np_q_count;
  logic [15:0]       np_err_cnt;

  logic [AWIDTH-1:0] a  [NREQS];
  logic [MWIDTH-1:0] wd [NREQS];
  assign req_addr  = {a[3], a[2], a[1], a[0]};
  assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

  mic_rr_queue #(.NREQS(NREQS), .PSIZE(PSIZE), .MWIDTH(MWIDTH), .RDEPTH(RDEPTH), .PROTECT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_gnt(mem_gnt), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rid(rsp_rid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .q_count(q_count), .err_cnt(err_cnt));

  mic_rr_queue #(.NREQS(NREQS), .PSIZE(PSIZE), .MWIDTH(MWIDTH), .RDEPTH(RDEPTH), .PROTECT(0)) u_np (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(np_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_gnt(mem_gnt), .mem_en(np_mem_en),
    .mem_we(np_mem_we), .mem_addr(np_mem_addr), .mem_wdata(np_mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(np_rsp_valid), .rsp_rid(np_rsp_rid), .rsp_err(np_rsp_err), .rsp_rdata(np_rsp_rdata),
    .q_count(np_q_count), .err_cnt(np_err_cnt));

  // Read-only memory model: registered read data one cycle after an issued read.
  function automatic logic [31:0] mem_val(input logic [AWIDTH-1:0] ad);
    return (ad == 7'd45) ? 32'hDEADBEEF : {16'hA5A5, 9'd0, ad};
  endfunction

  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);

  int errors = 0;
  int checks = 0;
  int pushed, popped, order_err, rsp_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; mem_gnt = 1'b0;
    step(); step();
    rst = 1'b0;
    pushed = 0; popped = 0; order_err = 0; rsp_seen = 0;
  endtask

  // Requestor 0 streams writes tagged with a sequence number; the head is
  // checked against that sequence whenever it issues.
  task automatic sb_cycle();
    a[0]  = AWIDTH'(pushed % 20);
    wd[0] = 32'(pushed);
    @(negedge clk);
    if (req_ready[0]) pushed++;
    if (mem_en) begin
      if (mem_wdata !== 32'(popped) || mem_addr !== AWIDTH'(popped % 20)) order_err++;
      popped++;
    end
    if (rsp_valid) rsp_seen++;
    step();
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       gnt;
    logic [3:0] ready;
    logic [2:0] count;
    logic       men;
    logic       rv;
    logic [1:0] rid;
  } vec_t;

  vec_t tbl [12];
  int   cnt [NREQS];

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 3'd1, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b1001, 1'b1, 4'b1000, 3'd2, 1'b1, 1'b0, 2'd0};
    tbl[3]  = '{4'b0110, 1'b1, 4'b0010, 3'd2, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 3'd2, 1'b1, 1'b1, 2'd1};
    tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 3'd1, 1'b0, 1'b1, 2'd3};
    tbl[6]  = '{4'b0101, 1'b0, 4'b0001, 3'd2, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 2'd0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 3'd2, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 3'd1, 1'b1, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0};

    for (int r = 0; r < NREQS; r++) begin
      a[r]  = AWIDTH'(r * 21);
      wd[r] = '0;
    end
    req_we = '0;

    // Reset state, with requests and grant held active during reset.
    rst = 1'b1; req_valid = 4'b1111; mem_gnt = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rid", rsp_rid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_q_count", q_count, 0);
    step();
    rst = 1'b0; req_valid = '0; mem_gnt = 1'b0;

    // Arbitration / queue table.
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      mem_gnt   = tbl[i].gnt;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_count", i), q_count, tbl[i].count);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].men);
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rsp_rid", i), rsp_rid, tbl[i].rid);
      step();
    end

    // Single read latency.
    do_reset();
    a[2] = 7'd45; req_valid = 4'b0100; mem_gnt = 1'b1;
    @(negedge clk);
    chk("rd_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 45);
    chk("rd_mem_we", mem_we, 0);
    step();
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rid", rsp_rid, 2);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    a[2] = 7'd42;

    // Fairness over 100 grants.
    do_reset();
    for (int r = 0; r < NREQS; r++) cnt[r] = 0;
    req_valid = 4'b1111; mem_gnt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int r = 0; r < NREQS; r++) if (req_ready[r]) cnt[r]++;
      if (req_ready !== 4'(1 << (i % 4))) order_err++;
      step();
    end
    req_valid = '0;
    chk("fair_order", order_err, 0);
    for (int r = 0; r < NREQS; r++) chk($sformatf("fair_cnt%0d", r), cnt[r], 25);
    for (int i = 0; i < 4; i++) step();

    // Back-pressure: fill with mem_gnt low, then drain in order.
    do_reset();
    req_we = 4'b0001; req_valid = 4'b0001; mem_gnt = 1'b0;
    for (int i = 0; i < 10; i++) sb_cycle();
    chk("bp_accepted", pushed, 6);
    chk("bp_q_count", q_count, 6);
    chk("bp_ready", req_ready, 0);
    req_valid = '0; mem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) sb_cycle();
    chk("bp_popped", popped, 6);
    chk("bp_rsp_seen", rsp_seen, 6);
    chk("bp_order", order_err, 0);
    chk("bp_empty", q_count, 0);

    // Protection: requestor 1 writes outside its partition.
    do_reset();
    req_we = 4'b0010; a[1] = 7'd5; wd[1] = 32'h1234;
    req_valid = 4'b0010; mem_gnt = 1'b1;
    @(negedge clk);
    chk("prot_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("prot_mem_en", mem_en, 0);
    chk("prot_np_mem_en", np_mem_en, 1);
    chk("prot_np_addr", np_mem_addr, 5);
    step();
    @(negedge clk);
    chk("prot_rsp_valid", rsp_valid, 1);
    chk("prot_rsp_err", rsp_err, 1);
    chk("prot_rsp_rid", rsp_rid, 1);
    chk("prot_rsp_rdata", rsp_rdata, 0);
    chk("prot_err_cnt", err_cnt, 1);
    chk("prot_np_rsp_err", np_rsp_err, 0);
    step();
    a[1] = 7'd21;

    // Simultaneous push/pop at occupancy 3, then full-queue wrap.
    do_reset();
    req_we = 4'b0001; req_valid = 4'b0001; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) sb_cycle();
    chk("pp_count_before", q_count, 3);
    mem_gnt = 1'b1;
    sb_cycle();
    chk("pp_count_after", q_count, 3);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) sb_cycle();
    chk("wrap_full", q_count, 6);
    mem_gnt = 1'b1;
    for (int i = 0; i < 20; i++) sb_cycle();
    req_valid = '0;
    for (int i = 0; i < 10; i++) sb_cycle();
    chk("wrap_drained", q_count, 0);
    chk("wrap_popped", popped, pushed);
    chk("wrap_order", order_err, 0);

    // Reset with 4 entries queued.
    do_reset();
    req_valid = 4'b0001; mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) sb_cycle();
    chk("rq_count", q_count, 4);
    rst = 1'b1; req_valid = '0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("rq_mem_en_in_rst", mem_en, 0);
    step();
    rst = 1'b0; req_valid = 4'b1111;
    @(negedge clk);
    chk("rq_q_count", q_count, 0);
    chk("rq_mem_en", mem_en, 0);
    chk("rq_rsp_valid", rsp_valid, 0);
    chk("rq_rr", req_ready, 4'b0001);
    step();
    req_valid = '0;
    req_we = '0;
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
